// File: rtl/vga_rect_filler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_rect_filler: clipped filled-rectangle plotter for vga_adapter           |
// | Optional macro RECT_OUTLINE_EN adds an outline-only mode.                   |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
module vga_rect_filler #(
    parameter int X_BITS      = 8,
    parameter int Y_BITS      = 7,
    parameter int COLOUR_BITS = 3,
    parameter int H_RES       = 160,
    parameter int V_RES       = 120
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   start,
    input  logic [X_BITS-1:0]      x0,
    input  logic [Y_BITS-1:0]      y0,
    input  logic [X_BITS-1:0]      width,
    input  logic [Y_BITS-1:0]      height,
    input  logic [COLOUR_BITS-1:0] colour,
`ifdef RECT_OUTLINE_EN
    input  logic                   outline,
`endif
    output logic                   busy,
    output logic                   done,
    output logic [X_BITS-1:0]      x_out,
    output logic [Y_BITS-1:0]      y_out,
    output logic [COLOUR_BITS-1:0] colour_out,
    output logic                   plot
);

    localparam logic [X_BITS:0] c_x_max = (X_BITS+1)'(H_RES - 1);
    localparam logic [Y_BITS:0] c_y_max = (Y_BITS+1)'(V_RES - 1);
    localparam logic [X_BITS:0] c_x_lim = (X_BITS+1)'(H_RES);
    localparam logic [Y_BITS:0] c_y_lim = (Y_BITS+1)'(V_RES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRAW = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [X_BITS-1:0]      r_xs;
    logic [X_BITS-1:0]      r_xe;
    logic [X_BITS-1:0]      r_cx;
    logic [Y_BITS-1:0]      r_ys;
    logic [Y_BITS-1:0]      r_ye;
    logic [Y_BITS-1:0]      r_cy;
    logic [COLOUR_BITS-1:0] r_col;
    logic                   r_outline;

    logic                   w_outline;
    logic [X_BITS:0]        w_x_sum;
    logic [Y_BITS:0]        w_y_sum;
    logic [X_BITS-1:0]      w_xe;
    logic [Y_BITS-1:0]      w_ye;
    logic                   w_degen;
    logic                   w_last_col;
    logic                   w_last;
    logic [X_BITS-1:0]      w_nx;
    logic [Y_BITS-1:0]      w_ny;
    logic                   w_edge;

`ifdef RECT_OUTLINE_EN
    assign w_outline = outline;
`else
    assign w_outline = 1'b0;
`endif

    // End coordinates are formed one bit wider so a large width cannot wrap.
    assign w_x_sum = {1'b0, x0} + {1'b0, width} - 1'b1;
    assign w_y_sum = {1'b0, y0} + {1'b0, height} - 1'b1;
    assign w_xe    = (w_x_sum > c_x_max) ? c_x_max[X_BITS-1:0] : w_x_sum[X_BITS-1:0];
    assign w_ye    = (w_y_sum > c_y_max) ? c_y_max[Y_BITS-1:0] : w_y_sum[Y_BITS-1:0];
    assign w_degen = (width == '0) || (height == '0) ||
                     ({1'b0, x0} >= c_x_lim) || ({1'b0, y0} >= c_y_lim);

    assign w_last_col = (r_cx == r_xe);
    assign w_last     = w_last_col && (r_cy == r_ye);
    assign w_nx       = w_last_col ? r_xs : r_cx + 1'b1;
    assign w_ny       = w_last_col ? r_cy + 1'b1 : r_cy;
    assign w_edge     = (w_nx == r_xs) || (w_nx == r_xe) || (w_ny == r_ys) || (w_ny == r_ye);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_xs       <= '0;
            r_xe       <= '0;
            r_cx       <= '0;
            r_ys       <= '0;
            r_ye       <= '0;
            r_cy       <= '0;
            r_col      <= '0;
            r_outline  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            plot       <= 1'b0;
            x_out      <= '0;
            y_out      <= '0;
            colour_out <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                    plot <= 1'b0;
                    if (start) begin
                        busy      <= 1'b1;
                        r_xs      <= x0;
                        r_ys      <= y0;
                        r_xe      <= w_xe;
                        r_ye      <= w_ye;
                        r_col     <= colour;
                        r_outline <= w_outline;
                        if (w_degen) begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                        end else begin
                            // The origin is always on the perimeter, so it plots in both modes.
                            r_state    <= S_DRAW;
                            r_cx       <= x0;
                            r_cy       <= y0;
                            x_out      <= x0;
                            y_out      <= y0;
                            colour_out <= colour;
                            plot       <= 1'b1;
                        end
                    end
                end
                S_DRAW: begin
                    if (w_last) begin
                        r_state <= S_DONE;
                        plot    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        r_cx  <= w_nx;
                        r_cy  <= w_ny;
                        x_out <= w_nx;
                        y_out <= w_ny;
                        plot  <= !r_outline || w_edge;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    plot    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_rect_filler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vga_rect_filler: randomized self-checking bench for vga_rect_filler      |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
module tb_vga_rect_filler;

    localparam int H_RES = 160;
    localparam int V_RES = 120;

    logic       clock;
    logic       resetn;
    logic       start;
    logic [7:0] x0;
    logic [6:0] y0;
    logic [7:0] width;
    logic [6:0] height;
    logic [2:0] colour;
    logic       outline;
    logic       busy;
    logic       done;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour_out;
    logic       plot;

    int n_checks;
    int n_errors;
    int last_x;
    int last_y;
    int last_c;

    vga_rect_filler dut (
        .clock      (clock),
        .resetn     (resetn),
        .start      (start),
        .x0         (x0),
        .y0         (y0),
        .width      (width),
        .height     (height),
        .colour     (colour),
`ifdef RECT_OUTLINE_EN
        .outline    (outline),
`endif
        .busy       (busy),
        .done       (done),
        .x_out      (x_out),
        .y_out      (y_out),
        .colour_out (colour_out),
        .plot       (plot)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic scramble();
        x0      = 8'($urandom);
        y0      = 7'($urandom);
        width   = 8'($urandom);
        height  = 7'($urandom);
        colour  = 3'($urandom);
        outline = 1'($urandom);
    endtask

    // Called at a negedge in the first IDLE cycle; returns at the negedge of the DONE cycle.
    task automatic run_rect(input int ax, input int ay, input int aw, input int ah,
                            input int acol, input bit aol, input bit mid);
        int  xe, ye, k;
        bit  degen, ep;
        degen = (aw == 0) || (ah == 0) || (ax >= H_RES) || (ay >= V_RES);
        xe    = (ax + aw - 1 > H_RES - 1) ? H_RES - 1 : ax + aw - 1;
        ye    = (ay + ah - 1 > V_RES - 1) ? V_RES - 1 : ay + ah - 1;
        check_val("idle_busy", 32'(busy), 0);
        check_val("idle_done", 32'(done), 0);
        check_val("idle_plot", 32'(plot), 0);
        x0 = 8'(ax); y0 = 7'(ay); width = 8'(aw); height = 7'(ah);
        colour = 3'(acol); outline = aol; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        scramble();
        k = 0;
        if (!degen) begin
            for (int y = ay; y <= ye; y++) begin
                for (int x = ax; x <= xe; x++) begin
                    ep = !aol || (x == ax) || (x == xe) || (y == ay) || (y == ye);
                    check_val("draw_plot", 32'(plot), 32'(ep));
                    check_val("draw_x", 32'(x_out), x);
                    check_val("draw_y", 32'(y_out), y);
                    check_val("draw_colour", 32'(colour_out), acol);
                    check_val("draw_busy", 32'(busy), 1);
                    check_val("draw_done", 32'(done), 0);
                    start = mid && (k == 5);
                    if (start) scramble();
                    k++;
                    @(negedge clock);
                end
            end
            last_x = xe; last_y = ye; last_c = acol;
        end
        start = 1'b0;
        check_val("done_pulse", 32'(done), 1);
        check_val("done_busy", 32'(busy), 1);
        check_val("done_plot", 32'(plot), 0);
        check_val("hold_x", 32'(x_out), last_x);
        check_val("hold_y", 32'(y_out), last_y);
        check_val("hold_colour", 32'(colour_out), last_c);
        // A start during DONE must be ignored; the next idle check would catch acceptance.
        start = 1'($urandom);
        scramble();
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        last_x = 0; last_y = 0; last_c = 0;
        resetn = 1'b0; start = 1'b0;
        x0 = '0; y0 = '0; width = '0; height = '0; colour = '0; outline = 1'b0;
        repeat (3) @(negedge clock);
        check_val("rst_busy", 32'(busy), 0);
        check_val("rst_done", 32'(done), 0);
        check_val("rst_plot", 32'(plot), 0);
        check_val("rst_x", 32'(x_out), 0);
        check_val("rst_y", 32'(y_out), 0);
        check_val("rst_colour", 32'(colour_out), 0);
        resetn = 1'b1;
        @(negedge clock);

        run_rect(10, 5, 3, 2, 4, 1'b0, 1'b0);           @(negedge clock);
        run_rect(158, 118, 5, 5, 2, 1'b0, 1'b0);        @(negedge clock);
        run_rect(20, 20, 0, 3, 7, 1'b0, 1'b0);          @(negedge clock);
        run_rect(200, 20, 4, 3, 7, 1'b0, 1'b0);         @(negedge clock);
        run_rect(10, 120, 4, 3, 7, 1'b0, 1'b0);         @(negedge clock);
        run_rect(10, 10, 4, 0, 7, 1'b0, 1'b0);          @(negedge clock);
        run_rect(150, 0, 255, 1, 3, 1'b0, 1'b0);        @(negedge clock);
        run_rect(50, 50, 4, 4, 2, 1'b0, 1'b1);          @(negedge clock);

        // Abort a draw with reset after five plots.
        start = 1'b0;
        check_val("pre_abort_busy", 32'(busy), 0);
        x0 = 8'd30; y0 = 7'd40; width = 8'd4; height = 7'd4; colour = 3'd5; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_val("abort_plot", 32'(plot), 1);
            check_val("abort_x", 32'(x_out), 30 + i % 4);
            if (i < 4) @(negedge clock);
        end
        resetn = 1'b0;
        @(negedge clock);
        check_val("abort_busy", 32'(busy), 0);
        check_val("abort_done", 32'(done), 0);
        check_val("abort_plot0", 32'(plot), 0);
        check_val("abort_x0", 32'(x_out), 0);
        check_val("abort_y0", 32'(y_out), 0);
        check_val("abort_colour0", 32'(colour_out), 0);
        resetn = 1'b1;
        last_x = 0; last_y = 0; last_c = 0;
        @(negedge clock);
        check_val("abort_no_done", 32'(done), 0);

        run_rect(0, 0, 1, 1, 6, 1'b0, 1'b0);            @(negedge clock);
        run_rect(0, 0, 1, 1, 1, 1'b0, 1'b0);            @(negedge clock);
`ifdef RECT_OUTLINE_EN
        run_rect(20, 20, 4, 3, 5, 1'b1, 1'b0);          @(negedge clock);
        run_rect(157, 117, 6, 6, 3, 1'b1, 1'b0);        @(negedge clock);
`endif

        for (int n = 0; n < 40; n++) begin
            int rx, ry, rw, rh;
            bit ro;
            rx = $urandom_range(0, 175);
            ry = $urandom_range(0, 127);
            rw = $urandom_range(0, 12);
            rh = $urandom_range(0, 8);
`ifdef RECT_OUTLINE_EN
            ro = 1'($urandom);
`else
            ro = 1'b0;
`endif
            run_rect(rx, ry, rw, rh, $urandom_range(0, 7), ro, 1'($urandom));
            @(negedge clock);
        end

        start = 1'b0;
        check_val("final_busy", 32'(busy), 0);
        @(negedge clock);
        check_val("final_idle", 32'(busy), 0);
        check_val("final_plot", 32'(plot), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
